// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out lane serializer.
package piso_pkg;

   localparam int unsigned MAX_LANES = 64;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Dual-rail encode: rail 2i carries the bit, rail 2i+1 its complement; all-zero spacer when not valid.
   function automatic logic [2*MAX_LANES-1:0] dr_encode(input logic [MAX_LANES-1:0] bits,
                                                        input logic                  valid);
      logic [2*MAX_LANES-1:0] rails;
      rails = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         rails[2*i]   = bits[i] & valid;
         rails[2*i+1] = ~bits[i] & valid;
      end
      return rails;
   endfunction

endpackage

// File: rtl/vr_fifo.sv
// Small circular word buffer with registered occupancy, full and empty flags.
module vr_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               wdata,
   output logic [WIDTH-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push_c, do_pop_c;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign do_push_c = push & ~full_q & ~clr;
   assign do_pop_c  = pop & ~empty_q & ~clr;

   // Pointer and occupancy update; clr returns the buffer to its reset state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
      end
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/piso_lanes.sv
// Buffers parallel words and sends them LANES bits per beat as dual-rail codes,
// loading the next buffered word on the final handshake so words run back to back.
module piso_lanes
   import piso_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned LANES     = 1,
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          din_valid,
   output logic                          din_ready,
   input  logic [DATAWIDTH-1:0]          din_data,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic [2*LANES-1:0]            dout_data,
   output logic                          last,
   output logic [$clog2(DEPTH+1)-1:0]    level
);

   localparam int unsigned NBEATS = DATAWIDTH / LANES;
   localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int unsigned LW     = $clog2(DEPTH + 1);

   if (DATAWIDTH % LANES != 0) begin : g_bad_lanes
      $error("piso_lanes: DATAWIDTH must be a multiple of LANES");
   end
   if (DEPTH < 1) begin : g_bad_depth
      $error("piso_lanes: DEPTH must be at least 1");
   end
   if (LANES > MAX_LANES) begin : g_bad_width
      $error("piso_lanes: LANES exceeds dual-rail encoder width");
   end

   state_e                 state_q, state_d;
   logic [DATAWIDTH-1:0]   sh_q, sh_d;
   logic [BW-1:0]          beat_q, beat_d;
   logic [2*LANES-1:0]     rails_q, rails_d;
   logic                   last_q, last_d;
   logic                   ready_q, ready_d;
   logic [LW-1:0]          level_d;

   logic [DATAWIDTH-1:0]   head_c;
   logic [LW-1:0]          count_c;
   logic                   full_c, empty_c;
   logic                   push_c, pop_c, fire_c, final_c;
   logic [LANES-1:0]       lane_bits_c;

   assign fire_c  = (state_q == SEND) & dout_ready;
   assign final_c = (beat_q == BW'(NBEATS - 1));
   assign push_c  = din_valid & ready_q & ~full_c & ~flush;

   vr_fifo #(
      .WIDTH (DATAWIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .push  (push_c),
      .pop   (pop_c),
      .wdata (din_data),
      .rdata (head_c),
      .count (count_c),
      .full  (full_c),
      .empty (empty_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: flush wins; SEND falls back to IDLE only when the buffer has nothing left.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (!empty_c) state_d = SEND;
            SEND:    if (fire_c && final_c && empty_c) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Shift register, beat counter and the registered output image for the next cycle.
   always_comb begin
      pop_c  = 1'b0;
      sh_d   = sh_q;
      beat_d = beat_q;
      if (flush) begin
         beat_d = '0;
      end else if (state_q == IDLE) begin
         if (!empty_c) begin
            pop_c  = 1'b1;
            sh_d   = head_c;
            beat_d = '0;
         end
      end else if (fire_c) begin
         if (final_c) begin
            pop_c  = ~empty_c;
            sh_d   = head_c;
            beat_d = '0;
         end else begin
            sh_d   = (MSB_FIRST != 0) ? (sh_q << LANES) : (sh_q >> LANES);
            beat_d = beat_q + BW'(1);
         end
      end
      lane_bits_c = (MSB_FIRST != 0) ? sh_d[DATAWIDTH-1 -: LANES] : sh_d[LANES-1:0];
      rails_d     = (2*LANES)'(dr_encode(MAX_LANES'(lane_bits_c), state_d == SEND));
      last_d      = (state_d == SEND) & (beat_d == BW'(NBEATS - 1));
      level_d     = flush ? '0 : count_c + LW'(push_c) - LW'(pop_c);
      ready_d     = (level_d < LW'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q    <= '0;
         beat_q  <= '0;
         rails_q <= '0;
         last_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         sh_q    <= sh_d;
         beat_q  <= beat_d;
         rails_q <= rails_d;
         last_q  <= last_d;
         ready_q <= ready_d;
      end
   end

   assign dout_valid = (state_q == SEND);
   assign dout_data  = rails_q;
   assign last       = last_q;
   assign din_ready  = ready_q;
   assign level      = count_c;

endmodule

// File: doc/piso_lanes.md
PISO_LANES -- requirements
Module: piso_lanes

Interface
REQ-001 Parameter DATAWIDTH, default 8: width of each parallel input word.
REQ-002 Parameter LANES, default 1: data bits per output beat; DATAWIDTH % LANES != 0 shall be an elaboration error.
REQ-003 Parameter DEPTH, default 2: input buffer depth in words; DEPTH >= 1.
REQ-004 Parameter MSB_FIRST, default 0: 0 sends the lowest bits first, 1 sends the highest bits first.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of the buffered words and of the word being sent.
REQ-008 din  valid_ready_std_if.in  data DATAWIDTH  parallel word input.
REQ-009 dout  valid_ready_std_if.out  data 2*LANES  dual-rail serial beat output.
REQ-010 last  output  1  marks the final beat of a word.
REQ-011 level  output  $clog2(DEPTH+1)  number of words held in the buffer.

Function
REQ-012 NBEATS = DATAWIDTH/LANES beats shall be sent per word, using a beat counter of max(1,$clog2(NBEATS)) bits.
REQ-013 Beat k shall carry word bits [k*LANES +: LANES] when MSB_FIRST=0, and bits [(NBEATS-1-k)*LANES +: LANES] when MSB_FIRST=1.
REQ-014 Dual-rail lane i: while dout.valid=1, dout.data[2i]=bit and dout.data[2i+1]=~bit; while dout.valid=0, all dout.data bits shall be 0 (spacer).
REQ-015 din.ready = (level < DEPTH); a word is written to the buffer when din.valid & din.ready at a clock edge.
REQ-016 When the buffer is full, a push and a pop in the same cycle shall not pass through: din.ready stays 0 for that cycle.
REQ-017 FSM states: IDLE (no word loaded, dout.valid=0) and SEND (word loaded, dout.valid=1).
REQ-018 IDLE->SEND when level>0: the head word is loaded into the shift register and beat 0 is presented after that edge.
REQ-019 SEND, handshake (dout.valid & dout.ready) on a non-final beat: advance to the next beat, stay in SEND.
REQ-020 SEND, handshake on the final beat with level>0: load the next word in the same edge and stay in SEND, with no bubble cycle.
REQ-021 SEND, handshake on the final beat with level=0: go to IDLE.
REQ-022 Once dout.valid is asserted, dout.valid and dout.data shall hold stable until the handshake; flush is the only exception.
REQ-023 last = dout.valid & (beat counter == NBEATS-1); when NBEATS=1, last shall be high on every valid beat.
REQ-024 Latency: a word accepted at edge N into an empty block shall present beat 0 from edge N+1.
REQ-025 flush=1 at an edge: empty the buffer (level=0), go to IDLE, and drop dout.valid after that edge; a din handshake in the same cycle shall be discarded.
REQ-026 level shall update by +1 on push only, -1 on pop only, and be unchanged on simultaneous push and pop.

Reset
REQ-027 While rst_n=0: state IDLE, dout.valid=0, dout.data=0, last=0, level=0, din.ready=1, beat counter 0, buffer pointers 0.
REQ-028 Reset asserted mid-word shall discard all words immediately; the first beat after reset release comes only from a new din word.

Structure
REQ-029 Package piso_pkg shall hold the state enum (IDLE, SEND) and a dual-rail encode function (bit vector to 2*LANES rails).
REQ-030 The input buffer shall be a sub-module vr_fifo (parameters WIDTH, DEPTH, with outputs count, full and empty), instantiated once.

Verification
REQ-031 DATAWIDTH=8, LANES=1, MSB_FIRST=0, dout.ready=1; send 0xA5 -> dout.data sequence 01,10,01,10,10,01,10,01 (bit0 first), last on beat 8 only, then spacer 00.
REQ-032 DATAWIDTH=8, LANES=2, MSB_FIRST=1; send 0xB4 -> 4 beats with lanes {1,0},{1,1},{0,1},{0,0}; rails 0110,0101,1001,1010; last on beat 4.
REQ-033 DEPTH=2; push 3 words while dout.ready=0 -> din.ready=0 after 3 accepts (1 loaded, 2 buffered); level=2; then release ready -> 24 contiguous beats with no bubble between words.
REQ-034 Hold dout.ready=0 for 5 cycles mid-word -> dout.data and last stay constant throughout; on release the beat index resumes correctly.
REQ-035 Assert flush on beat 3 of word 0x3C with 1 word buffered -> after the edge dout.valid=0, level=0, din.ready=1; the next word pushed is sent from beat 0.
REQ-036 Assert rst_n=0 asynchronously mid-beat -> all outputs reach their REQ-027 values without waiting for a clock edge.
